// File: rtl/gray_stream_decoder_pkg.sv
// Shared definitions for the Gray-coded position stream decoder:
// FSM state encoding and default sizing constants.
package gray_stream_decoder_pkg;

  localparam int DEF_N      = 8;
  localparam int DEF_LOCK_N = 4;
  localparam int DEF_ERR_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACQ   = 2'd1,
    ST_TRACK = 2'd2
  } state_e;

endpackage : gray_stream_decoder_pkg

// File: rtl/gray_stream_decoder_if.sv
// Sample/status bundle between a Gray source, the decoder and its binary consumers.
// The master drives samples and clear; the slave (the decoder) returns status.
interface gray_stream_decoder_if #(
  parameter int N     = 8,
  parameter int ERR_W = 8
);
  logic             i_clr;
  logic             i_valid;
  logic [N-1:0]     i_gray;
  logic             o_valid;
  logic [N-1:0]     o_bin;
  logic             o_step;
  logic             o_dir_up;
  logic             o_err;
  logic [ERR_W-1:0] o_err_cnt;
  logic             o_locked;

  modport master (
    output i_clr, i_valid, i_gray,
    input  o_valid, o_bin, o_step, o_dir_up, o_err, o_err_cnt, o_locked
  );

  modport slave (
    input  i_clr, i_valid, i_gray,
    output o_valid, o_bin, o_step, o_dir_up, o_err, o_err_cnt, o_locked
  );
endinterface : gray_stream_decoder_if

// File: rtl/gray_stream_decoder_gray_to_bin.sv
// Combinational Gray-to-binary converter: each binary bit is the XOR of
// all Gray bits at and above its position.
module gray_to_bin #(
  parameter int N = 8
) (
  input  logic [N-1:0] gray_i,
  output logic [N-1:0] bin_o
);
  for (genvar k = 0; k < N; k++) begin : g_bit
    assign bin_o[k] = ^gray_i[N-1:k];
  end
endmodule : gray_to_bin

// File: rtl/gray_stream_decoder.sv
// Registers and decodes a Gray position stream, checks single-step continuity,
// reports direction, lock status and a saturating illegal-jump count.
module gray_stream_decoder
  import gray_stream_decoder_pkg::*;
#(
  parameter int N      = DEF_N,
  parameter int LOCK_N = DEF_LOCK_N,
  parameter int ERR_W  = DEF_ERR_W
) (
  input logic                  i_clk,
  input logic                  i_rstn,
  gray_stream_decoder_if.slave bus
);
  localparam int CNT_W = $clog2(LOCK_N + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d, lock_inc;
  logic [N-1:0]     bin_q, bin_d, bin_now, delta;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             dir_q, dir_d;
  logic             valid_q, valid_d;
  logic             step_q, step_d;
  logic             err_q, err_d;
  logic             step_up, step_dn;

  gray_to_bin #(.N(N)) u_g2b (
    .gray_i(bus.i_gray),
    .bin_o (bin_now)
  );

  // bin_q doubles as the previous accepted position; N-bit subtraction gives the wrap.
  assign delta    = bin_now - bin_q;
  assign step_up  = (delta == N'(1));
  assign step_dn  = (delta == '1);
  assign lock_inc = lock_cnt_q + CNT_W'(1);

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    bin_d      = bin_q;
    dir_d      = dir_q;
    err_cnt_d  = err_cnt_q;
    valid_d    = 1'b0;
    step_d     = 1'b0;
    err_d      = 1'b0;

    if (bus.i_clr) begin
      state_d    = ST_IDLE;
      lock_cnt_d = '0;
      err_cnt_d  = '0;
    end else if (bus.i_valid) begin
      valid_d = 1'b1;
      bin_d   = bin_now;
      if (state_q == ST_IDLE) begin
        state_d    = ST_ACQ;
        lock_cnt_d = '0;
      end else if (step_up || step_dn) begin
        step_d = 1'b1;
        dir_d  = step_up;
        if (state_q == ST_ACQ) begin
          lock_cnt_d = lock_inc;
          if (lock_inc == CNT_W'(LOCK_N)) state_d = ST_TRACK;
        end
      end else if (delta != '0) begin
        err_d      = 1'b1;
        state_d    = ST_ACQ;
        lock_cnt_d = '0;
        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q    <= ST_IDLE;
      lock_cnt_q <= '0;
      bin_q      <= '0;
      dir_q      <= 1'b0;
      err_cnt_q  <= '0;
      valid_q    <= 1'b0;
      step_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      bin_q      <= bin_d;
      dir_q      <= dir_d;
      err_cnt_q  <= err_cnt_d;
      valid_q    <= valid_d;
      step_q     <= step_d;
      err_q      <= err_d;
    end
  end

  assign bus.o_valid   = valid_q;
  assign bus.o_bin     = bin_q;
  assign bus.o_step    = step_q;
  assign bus.o_dir_up  = dir_q;
  assign bus.o_err     = err_q;
  assign bus.o_err_cnt = err_cnt_q;
  assign bus.o_locked  = (state_q == ST_TRACK);
endmodule : gray_stream_decoder

// File: tb/tb_gray_stream_decoder.sv
// Directed bench for gray_stream_decoder: two instances (ERR_W=8 and ERR_W=2) share
// stimulus and are compared every cycle against an integer model, plus literal checks.
module tb_gray_stream_decoder;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  bit   cmp_en = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  gray_stream_decoder_if #(.N(8), .ERR_W(8)) bus0 ();
  gray_stream_decoder_if #(.N(8), .ERR_W(2)) bus1 ();

  gray_stream_decoder #(.N(8), .LOCK_N(4), .ERR_W(8)) dut0 (
    .i_clk(clk), .i_rstn(rst_n), .bus(bus0)
  );
  gray_stream_decoder #(.N(8), .LOCK_N(4), .ERR_W(2)) dut1 (
    .i_clk(clk), .i_rstn(rst_n), .bus(bus1)
  );

  typedef struct {
    int idle;
    int bin;
    int dir;
    int valid;
    int step;
    int err;
    int errc;
    int lock;
    int locked;
  } mstate_t;

  mstate_t m0, m1;

  function automatic mstate_t model_reset();
    mstate_t s;
    s.idle = 1; s.bin = 0; s.dir = 0; s.valid = 0; s.step = 0;
    s.err = 0; s.errc = 0; s.lock = 0; s.locked = 0;
    return s;
  endfunction

  // Decode by search: the binary value whose Gray code equals g.
  function automatic int gray_decode(int g);
    for (int b = 0; b < 256; b++) if ((b ^ (b >> 1)) == g) return b;
    return -1;
  endfunction

  function automatic mstate_t model_step(mstate_t s, bit clr, bit valid, int g, int errmax);
    mstate_t n = s;
    int b, d;
    n.valid = 0; n.step = 0; n.err = 0;
    if (clr) begin
      n.idle = 1; n.lock = 0; n.locked = 0; n.errc = 0;
      return n;
    end
    if (!valid) return n;
    b = gray_decode(g);
    n.valid = 1;
    n.bin   = b;
    if (s.idle != 0) begin
      n.idle = 0; n.lock = 0;
      return n;
    end
    d = (b - s.bin + 256) % 256;
    if (d == 0) return n;
    if (d == 1 || d == 255) begin
      n.step = 1;
      n.dir  = (d == 1) ? 1 : 0;
      if (s.locked == 0) begin
        n.lock = s.lock + 1;
        if (n.lock >= 4) n.locked = 1;
      end
    end else begin
      n.err = 1;
      if (s.errc < errmax) n.errc = s.errc + 1;
      n.lock = 0; n.locked = 0;
    end
    return n;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, sampled away from the rising edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("d0_valid",  32'(bus0.o_valid),   32'(m0.valid));
      check("d0_bin",    32'(bus0.o_bin),     32'(m0.bin));
      check("d0_step",   32'(bus0.o_step),    32'(m0.step));
      check("d0_dir",    32'(bus0.o_dir_up),  32'(m0.dir));
      check("d0_err",    32'(bus0.o_err),     32'(m0.err));
      check("d0_errcnt", 32'(bus0.o_err_cnt), 32'(m0.errc));
      check("d0_locked", 32'(bus0.o_locked),  32'(m0.locked));
      check("d1_valid",  32'(bus1.o_valid),   32'(m1.valid));
      check("d1_bin",    32'(bus1.o_bin),     32'(m1.bin));
      check("d1_err",    32'(bus1.o_err),     32'(m1.err));
      check("d1_errcnt", 32'(bus1.o_err_cnt), 32'(m1.errc));
      check("d1_locked", 32'(bus1.o_locked),  32'(m1.locked));
    end
  end

  task automatic drive(input bit clr, input bit valid, input int bin);
    logic [7:0] g;
    @(negedge clk); #1;
    g = 8'(bin ^ (bin >> 1));
    bus0.i_clr = clr; bus0.i_valid = valid; bus0.i_gray = g;
    bus1.i_clr = clr; bus1.i_valid = valid; bus1.i_gray = g;
    m0 = model_step(m0, clr, valid, int'(g), 255);
    m1 = model_step(m1, clr, valid, int'(g), 3);
  endtask

  task automatic settle();
    @(posedge clk); #1;
  endtask

  initial begin
    int lock_exp [5] = '{0, 0, 0, 0, 1};
    int cnt2_exp [5] = '{1, 2, 3, 3, 3};
    int jumps    [5] = '{40, 80, 120, 160, 200};

    m0 = model_reset();
    m1 = model_reset();
    bus0.i_clr = 1'b0; bus0.i_valid = 1'b0; bus0.i_gray = '0;
    bus1.i_clr = 1'b0; bus1.i_valid = 1'b0; bus1.i_gray = '0;
    cmp_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_bin",    32'(bus0.o_bin),     32'd0);
    check("rst_locked", 32'(bus0.o_locked),  32'd0);
    check("rst_errcnt", 32'(bus0.o_err_cnt), 32'd0);
    @(negedge clk); #1;
    rst_n = 1'b1;

    // 1: acquire on 0..4
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, i);
      settle();
      check("t1_valid",  32'(bus0.o_valid),  32'd1);
      check("t1_bin",    32'(bus0.o_bin),    32'(i));
      check("t1_step",   32'(bus0.o_step),   (i == 0) ? 32'd0 : 32'd1);
      check("t1_locked", 32'(bus0.o_locked), 32'(lock_exp[i]));
    end
    check("t1_dir",    32'(bus0.o_dir_up),  32'd1);
    check("t1_errcnt", 32'(bus0.o_err_cnt), 32'd0);

    // 2: walk down to 255, then wrap up to 0 and back down
    for (int b = 3; b >= 0; b--) drive(0, 1, b);
    drive(0, 1, 255);
    drive(0, 1, 0);
    settle();
    check("t2_up_step", 32'(bus0.o_step),   32'd1);
    check("t2_up_dir",  32'(bus0.o_dir_up), 32'd1);
    check("t2_up_err",  32'(bus0.o_err),    32'd0);
    drive(0, 1, 255);
    settle();
    check("t2_dn_dir",    32'(bus0.o_dir_up), 32'd0);
    check("t2_dn_locked", 32'(bus0.o_locked), 32'd1);

    // 3: illegal jump 10 -> 13, then relock on 14..17
    for (int b = 0; b <= 10; b++) drive(0, 1, b);
    drive(0, 1, 13);
    settle();
    check("t3_err",    32'(bus0.o_err),     32'd1);
    check("t3_errcnt", 32'(bus0.o_err_cnt), 32'd1);
    check("t3_locked", 32'(bus0.o_locked),  32'd0);
    check("t3_bin",    32'(bus0.o_bin),     32'd13);
    for (int b = 14; b <= 16; b++) drive(0, 1, b);
    settle();
    check("t3_not_yet", 32'(bus0.o_locked), 32'd0);
    drive(0, 1, 17);
    settle();
    check("t3_relock", 32'(bus0.o_locked), 32'd1);

    // 4: saturation of the 2-bit counter
    drive(1, 0, 0);
    drive(0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, jumps[i]);
      settle();
      check("t4_err",     32'(bus1.o_err),     32'd1);
      check("t4_cnt2",    32'(bus1.o_err_cnt), 32'(cnt2_exp[i]));
      check("t4_cnt8",    32'(bus0.o_err_cnt), 32'(i + 1));
    end

    // 5: clear wins over a simultaneous sample
    drive(1, 0, 0);
    drive(0, 1, 10);
    drive(0, 1, 50);
    drive(0, 1, 90);
    settle();
    check("t5_pre_cnt", 32'(bus0.o_err_cnt), 32'd2);
    drive(1, 1, 91);
    settle();
    check("t5_clr_cnt",   32'(bus0.o_err_cnt), 32'd0);
    check("t5_clr_valid", 32'(bus0.o_valid),   32'd0);
    check("t5_clr_bin",   32'(bus0.o_bin),     32'd90);
    drive(0, 1, 200);
    settle();
    check("t5_first_valid", 32'(bus0.o_valid), 32'd1);
    check("t5_first_step",  32'(bus0.o_step),  32'd0);
    check("t5_first_err",   32'(bus0.o_err),   32'd0);
    for (int b = 201; b <= 204; b++) drive(0, 1, b);
    settle();
    check("t5_locked", 32'(bus0.o_locked), 32'd1);

    // 6: asynchronous reset between edges while tracking
    drive(0, 0, 0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    m0 = model_reset();
    m1 = model_reset();
    #1;
    check("t6_rst_bin",    32'(bus0.o_bin),     32'd0);
    check("t6_rst_locked", 32'(bus0.o_locked),  32'd0);
    check("t6_rst_dir",    32'(bus0.o_dir_up),  32'd0);
    check("t6_rst_valid",  32'(bus0.o_valid),   32'd0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, 77);
      settle();
      check("t6_valid", 32'(bus0.o_valid), 32'd1);
      check("t6_step",  32'(bus0.o_step),  32'd0);
      check("t6_err",   32'(bus0.o_err),   32'd0);
      check("t6_bin",   32'(bus0.o_bin),   32'd77);
    end
    drive(0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    cmp_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule : tb_gray_stream_decoder
